// File: rtl/rv_mem_responder.sv
// Slave end of the core's request/grant/response bus: word-organised RAM with
// byte-enable writes, programmable wait states and error responses.
module rv_mem_responder #(
  parameter int XLEN        = 32,
  parameter int MEM_LEN     = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic            req_i,
  input  logic            we_i,
  input  logic [3:0]      be_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            gnt_o,
  output logic            rvalid_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            err_o
);

  // state | meaning
  // IDLE  | ready; grant follows req_i
  // WAIT  | counting down wait states
  // RESP  | one-cycle response strobe
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int         DEPTH    = 2 ** (MEM_LEN - 2);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               grant, resp_load;
  logic               we_q, err_q;
  logic [MEM_LEN-3:0] idx_q, idx_in, idx_src;
  logic               we_src, err_src;
  logic               range_err, be_bad, misaligned, req_err;
  logic [XLEN-1:0]    mem [DEPTH];

  assign idx_in    = addr_i[MEM_LEN-1:2];
  assign range_err = |(addr_i >> MEM_LEN);

  always_comb begin
    be_bad     = 1'b0;
    misaligned = 1'b0;
    case (be_i)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: misaligned = 1'b0;
      4'b0011, 4'b1100:                   misaligned = addr_i[0];
      4'b1111:                            misaligned = |addr_i[1:0];
      default:                            be_bad     = 1'b1;
    endcase
  end

  assign req_err = range_err | be_bad | misaligned;

  // With zero wait states the response is loaded on the grant edge itself,
  // so the request fields come straight from the inputs in that case.
  assign we_src  = (state_q == IDLE) ? we_i    : we_q;
  assign err_src = (state_q == IDLE) ? req_err : err_q;
  assign idx_src = (state_q == IDLE) ? idx_in  : idx_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant     = 1'b0;
    resp_load = 1'b0;
    case (state_q)
      IDLE: begin
        grant = req_i & arstn_i;
        if (grant) begin
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d   = RESP;
            resp_load = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d   = RESP;
          resp_load = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign gnt_o    = grant;
  assign rvalid_o = (state_q == RESP);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      rdata_o <= '0;
      err_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grant) begin
        we_q  <= we_i;
        err_q <= req_err;
        idx_q <= idx_in;
      end
      if (resp_load) begin
        err_o   <= err_src;
        rdata_o <= (err_src || we_src) ? '0 : mem[idx_src];
      end
    end
  end

  // Memory contents survive reset; writes commit on the grant edge.
  always_ff @(posedge clk_i) begin
    if (grant && we_i && !req_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem[idx_in][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_rv_mem_responder.sv
// Scoreboard bench for rv_mem_responder: two instances (3 and 0 wait states)
// driven by directed and random requests against a word-array reference model.
module tb_rv_mem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [1:0]       arstn, req, we;
  logic [1:0][3:0]  be;
  logic [1:0][31:0] addr, wdata;
  logic             gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [31:0]      rdata0, rdata1;

  rv_mem_responder #(.XLEN(32), .MEM_LEN(18), .WAIT_CYCLES(3)) u_dut_w3 (
    .clk_i(clk), .arstn_i(arstn[0]), .req_i(req[0]), .we_i(we[0]), .be_i(be[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .gnt_o(gnt0), .rvalid_o(rvalid0),
    .rdata_o(rdata0), .err_o(err0)
  );

  rv_mem_responder #(.XLEN(32), .MEM_LEN(18), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk_i(clk), .arstn_i(arstn[1]), .req_i(req[1]), .we_i(we[1]), .be_i(be[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .gnt_o(gnt1), .rvalid_o(rvalid1),
    .rdata_o(rdata1), .err_o(err1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] m0 [int];
  logic [31:0] m1 [int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int wc(input int d);
    return (d == 0) ? 3 : 0;
  endfunction

  function automatic logic gnt_of(input int d);
    return (d == 0) ? gnt0 : gnt1;
  endfunction

  // Error rules: out of the 256 KiB window, illegal lane pattern, or misaligned.
  function automatic bit ref_err(input logic [31:0] a, input logic [3:0] b);
    if (a >= 32'h0004_0000) return 1'b1;
    case (b)
      4'd1, 4'd2, 4'd4, 4'd8: return 1'b0;
      4'd3, 4'd12:            return a[0];
      4'd15:                  return a[1:0] != 2'b00;
      default:                return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input int d, input int idx);
    if (d == 0) return m0.exists(idx) ? m0[idx] : 32'h0;
    return m1.exists(idx) ? m1[idx] : 32'h0;
  endfunction

  task automatic model_write(input int d, input int idx, input logic [3:0] b, input logic [31:0] wd);
    logic [31:0] w;
    w = model_read(d, idx);
    for (int i = 0; i < 4; i++) if (b[i]) w[8*i +: 8] = wd[8*i +: 8];
    if (d == 0) m0[idx] = w;
    else m1[idx] = w;
  endtask

  // Called just after a falling edge; returns just after the next falling edge
  // following the grant. keep=1 leaves req high for a back-to-back request.
  task automatic do_req(input int d, input bit w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] wd, input bit keep, output int gcyc, output int waited);
    exp_t x;
    bit   got;
    int   idx;
    got = 1'b0;
    waited = 0;
    gcyc = -1;
    we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd; req[d] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (gnt_of(d) === 1'b1) begin
        got = 1'b1;
        gcyc = cyc;
        break;
      end
      waited++;
      @(negedge clk);
    end
    if (!got) begin
      chk($sformatf("gnt_timeout%0d", d), 32'd0, 32'd1);
      req[d] = 1'b0;
      @(negedge clk);
      return;
    end
    x.err = ref_err(a, b);
    idx = int'(a[17:2]);
    if (w && !x.err) model_write(d, idx, b, wd);
    x.rdata = (x.err || w) ? 32'h0 : model_read(d, idx);
    x.due = gcyc + 1 + wc(d);
    if (d == 0) q0.push_back(x);
    else q1.push_back(x);
    @(negedge clk);
    if (!keep) req[d] = 1'b0;
  endtask

  task automatic mon(input int d, input logic [31:0] rd, input logic e);
    exp_t x;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      chk($sformatf("unexpected_rvalid%0d", d), 32'd1, 32'd0);
    end else begin
      if (d == 0) x = q0.pop_front();
      else x = q1.pop_front();
      chk($sformatf("rdata%0d", d), rd, x.rdata);
      chk($sformatf("err%0d", d), {31'd0, e}, {31'd0, x.err});
      chk($sformatf("latency%0d", d), cyc, x.due);
    end
  endtask

  always @(negedge clk) begin
    if (rvalid0 === 1'b1) mon(0, rdata0, err0);
    if (rvalid1 === 1'b1) mon(1, rdata1, err1);
  end

  task automatic init_region(input int d);
    int g, wt;
    for (int i = 0; i < 16; i++) do_req(d, 1'b1, 4'hF, 32'h100 + 32'(4*i), $urandom, 1'b0, g, wt);
  endtask

  task automatic rand_ops(input int d, input int n);
    logic [3:0]  legal [7];
    logic [3:0]  b;
    logic [31:0] a;
    int g, wt;
    legal = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    for (int i = 0; i < n; i++) begin
      a = 32'h100 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(18, 31));
      if ($urandom_range(0, 3) == 0) b = 4'($urandom_range(0, 15));
      else b = legal[$urandom_range(0, 6)];
      do_req(d, 1'($urandom), b, a, $urandom, 1'($urandom), g, wt);
    end
    req[d] = 1'b0;
  endtask

  initial begin
    int g, wt, g0, g1, g2;
    arstn = 2'b00; req = 2'b00; we = 2'b00; be = '0; addr = '0; wdata = '0;
    #2 req = 2'b11;
    #1;
    chk("reset_gnt0", {31'd0, gnt0}, 32'd0);
    chk("reset_gnt1", {31'd0, gnt1}, 32'd0);
    chk("reset_rvalid0", {31'd0, rvalid0}, 32'd0);
    chk("reset_rvalid1", {31'd0, rvalid1}, 32'd0);
    chk("reset_rdata0", rdata0, 32'd0);
    chk("reset_err1", {31'd0, err1}, 32'd0);
    req = 2'b00;
    @(negedge clk); @(negedge clk);
    arstn = 2'b11;

    // directed lane and error cases, 3 wait states
    do_req(0, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 1'b0, g, wt);
    do_req(0, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0, g, wt);
    do_req(0, 1'b1, 4'b0010, 32'h101, 32'h0000_00AA, 1'b0, g, wt);
    do_req(0, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0, g, wt);
    do_req(0, 1'b1, 4'b1100, 32'h102, 32'h1234_0000, 1'b0, g, wt);
    do_req(0, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0, g, wt);
    do_req(0, 1'b0, 4'hF, 32'h0004_0000, 32'h0, 1'b0, g, wt);
    do_req(0, 1'b1, 4'hF, 32'h200, 32'hCAFEF00D, 1'b0, g, wt);
    do_req(0, 1'b1, 4'b0110, 32'h200, 32'hFFFF_FFFF, 1'b0, g, wt);
    do_req(0, 1'b0, 4'hF, 32'h202, 32'h0, 1'b0, g, wt);
    do_req(0, 1'b0, 4'hF, 32'h200, 32'h0, 1'b0, g, wt);

    // reset while the next read is waiting
    do_req(0, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0, g, wt);
    arstn[0] = 1'b0;
    #1;
    chk("midreset_rvalid", {31'd0, rvalid0}, 32'd0);
    chk("midreset_rdata", rdata0, 32'd0);
    chk("midreset_err", {31'd0, err0}, 32'd0);
    chk("midreset_pending", q0.size(), 32'd1);
    if (q0.size() > 0) void'(q0.pop_back());
    @(negedge clk); @(negedge clk);
    arstn[0] = 1'b1;
    do_req(0, 1'b0, 4'hF, 32'h200, 32'h0, 1'b0, g, wt);
    chk("post_reset_grant_wait", wt, 32'd0);
    repeat (6) @(negedge clk);

    init_region(0);
    rand_ops(0, 40);

    // zero wait states: back-to-back, then a withdrawn request
    init_region(1);
    do_req(1, 1'b0, 4'hF, 32'h104, 32'h0, 1'b1, g0, wt);
    do_req(1, 1'b0, 4'hF, 32'h108, 32'h0, 1'b1, g1, wt);
    do_req(1, 1'b0, 4'hF, 32'h10C, 32'h0, 1'b0, g2, wt);
    chk("b2b_spacing01", g1 - g0, 32'd2);
    chk("b2b_spacing12", g2 - g1, 32'd2);
    do_req(1, 1'b0, 4'hF, 32'h110, 32'h0, 1'b0, g, wt);
    addr[1] = 32'h114; req[1] = 1'b1;
    #1;
    chk("withdraw_gnt", {31'd0, gnt1}, 32'd0);
    @(negedge clk);
    req[1] = 1'b0;
    repeat (5) @(negedge clk);
    rand_ops(1, 40);

    for (int i = 0; i < 60 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    chk("drain0", q0.size(), 32'd0);
    chk("drain1", q1.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
